// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, bit timing constant and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_ODD   = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam int BIT_TICKS = 16;

  // Parity covers only the bits that go on the wire (7 or 8)
  function automatic logic parity_bit(input logic [7:0] data, input logic len8,
                                      input logic [1:0] sel);
    logic x;
    x = len8 ? ^data : ^data[6:0];
    case (sel)
      PAR_ODD:  parity_bit = ~x;
      PAR_EVEN: parity_bit = x;
      PAR_MARK: parity_bit = 1'b1;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - 16x oversampling tick counter producing a bit_end pulse
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic i_clear,
  input  logic i_ce,
  output logic o_bit_end
);

  logic [3:0] r_cnt;

  assign o_bit_end = i_ce & ~i_clear & (r_cnt == 4'(BIT_TICKS - 1));

  // Count 16x enables within a bit; the counter wraps to 0 at the bit boundary
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_ce) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer fed from a first-word-fall-through FIFO
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CE_16x,
  input  logic             EF,
  input  logic [width-1:0] DO,
  output logic             RE,
  input  logic             Len,
  input  logic             NumStop,
  input  logic             ParEn,
  input  logic [1:0]       ParSel,
  input  logic             Brk,
  output logic             TxD,
  output logic             TxBusy,
  output logic             TxIdle
);

  tx_state_t  r_state;
  logic [7:0] r_thr;
  logic [2:0] r_bitcnt;
  logic       r_len;
  logic       r_nstop;
  logic       r_par_en;
  logic       r_par;
  logic       r_txd;

  logic w_bit_end;
  logic w_line;
  logic w_unused_do;

  // Only the low byte is transmitted
  assign w_unused_do = ^DO[width-1:8];

  // Pop is gated by reset so the FIFO never loses a word while the block is held
  assign RE     = (r_state == IDLE) & ~EF & ~Rst;
  assign TxBusy = (r_state != IDLE);
  assign TxIdle = ~TxBusy & EF;
  assign TxD    = r_txd;

  uart_bit_timer u_bit_timer (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_clear   (r_state == IDLE),
    .i_ce      (CE_16x),
    .o_bit_end (w_bit_end)
  );

  // Line level belonging to the current state, used while a bit is being held
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      START:   w_line = 1'b0;
      DATA:    w_line = r_thr[0];
      PARITY:  w_line = r_par;
      default: w_line = 1'b1;
    endcase
  end

  // Frame sequencer; TxD is loaded with the level of the state being entered
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= IDLE;
      r_thr    <= '0;
      r_bitcnt <= '0;
      r_len    <= 1'b0;
      r_nstop  <= 1'b0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_txd    <= 1'b1;
    end else begin
      r_txd <= w_line;
      case (r_state)
        IDLE: begin
          if (!EF) begin
            r_thr    <= DO[7:0];
            r_len    <= Len;
            r_nstop  <= NumStop;
            r_par_en <= ParEn;
            r_par    <= parity_bit(DO[7:0], Len, ParSel);
            r_bitcnt <= '0;
            r_state  <= START;
            r_txd    <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_txd   <= r_thr[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bitcnt == (r_len ? 3'd7 : 3'd6)) begin
              r_bitcnt <= '0;
              if (r_par_en) begin
                r_state <= PARITY;
                r_txd   <= r_par;
              end else begin
                r_state <= STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_thr    <= r_thr >> 1;
              r_txd    <= r_thr[1];
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            r_txd   <= 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (r_bitcnt == {2'b00, r_nstop}) begin
              r_state <= IDLE;
              r_txd   <= 1'b1;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
        end
      endcase
      if (Brk) begin
        r_txd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        CE_16x;
  logic        EF;
  logic [15:0] DO;
  logic        RE;
  logic        Len;
  logic        NumStop;
  logic        ParEn;
  logic [1:0]  ParSel;
  logic        Brk;
  logic        TxD;
  logic        TxBusy;
  logic        TxIdle;

  always #5 Clk = ~Clk;

  uart_tx_serializer #(.width(16)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .CE_16x  (CE_16x),
    .EF      (EF),
    .DO      (DO),
    .RE      (RE),
    .Len     (Len),
    .NumStop (NumStop),
    .ParEn   (ParEn),
    .ParSel  (ParSel),
    .Brk     (Brk),
    .TxD     (TxD),
    .TxBusy  (TxBusy),
    .TxIdle  (TxIdle)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ce_div = 1;
  bit rand_cfg = 0;
  bit rand_brk = 0;

  logic [15:0] fifo[$];
  int          re_log[$];
  bit          txd_log [0:65535];
  bit          busy_log[0:65535];

  // Reference: a frame is a list of line levels, each held for 16 enables
  bit m_bits[$];
  int m_ticks = 0;
  bit m_busy = 0;
  bit m_txd = 1;

  bit p1 [0:9]  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  bit p2 [0:10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic build_frame(input logic [7:0] w);
    int n;
    int ones;
    m_bits.delete();
    m_bits.push_back(1'b0);
    n = Len ? 8 : 7;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      m_bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (ParEn) begin
      case (ParSel)
        2'b00:   m_bits.push_back((ones % 2) == 0);
        2'b01:   m_bits.push_back((ones % 2) == 1);
        2'b10:   m_bits.push_back(1'b1);
        default: m_bits.push_back(1'b0);
      endcase
    end
    for (int i = 0; i < (NumStop ? 2 : 1); i++) m_bits.push_back(1'b1);
  endtask

  task automatic model_edge();
    if (Rst) begin
      m_busy = 0;
      m_ticks = 0;
      m_bits.delete();
    end else if (!m_busy) begin
      if (!EF) begin
        build_frame(DO[7:0]);
        void'(fifo.pop_front());
        m_busy = 1;
        m_ticks = 0;
      end
    end else if (CE_16x) begin
      m_ticks++;
      if (m_ticks == 16) begin
        m_ticks = 0;
        void'(m_bits.pop_front());
        if (m_bits.size() == 0) m_busy = 0;
      end
    end
    if (Rst) m_txd = 1;
    else     m_txd = Brk ? 1'b0 : (m_busy ? m_bits[0] : 1'b1);
  endtask

  task automatic drive_inputs();
    EF = (fifo.size() == 0);
    DO = EF ? 16'($urandom) : fifo[0];
    CE_16x = ((cyc % ce_div) == 0);
    if (rand_cfg) begin
      Len     = 1'($urandom);
      NumStop = 1'($urandom);
      ParEn   = 1'($urandom);
      ParSel  = 2'($urandom);
    end
    if (rand_brk && ($urandom_range(0, 99) == 0)) Brk = ~Brk;
  endtask

  task automatic check_outputs();
    if (cyc < 65536) begin
      txd_log[cyc]  = TxD;
      busy_log[cyc] = TxBusy;
    end
    if (RE === 1'b1) re_log.push_back(cyc);
    chk("txd", TxD, m_txd);
    chk("busy", TxBusy, m_busy);
    chk("idle", TxIdle, !m_busy && EF);
    chk("re", RE, !m_busy && !EF && !Rst);
  endtask

  task automatic cycle();
    @(posedge Clk);
    cyc++;
    model_edge();
    #1;
    drive_inputs();
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((m_busy || fifo.size() != 0) && n < max) begin
      cycle();
      n++;
    end
    chk("drain", (m_busy || fifo.size() != 0), 0);
    repeat (3) cycle();
  endtask

  task automatic wait_re(output int r);
    int n = 0;
    while (re_log.size() == 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("re_seen", re_log.size() != 0, 1);
    r = (re_log.size() != 0) ? re_log[0] : cyc;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int cnt;

    Rst = 1; CE_16x = 0; EF = 1; DO = '0; Brk = 0;
    Len = 1; NumStop = 0; ParEn = 0; ParSel = 2'b00;
    #1;
    chk("rst_txd", TxD, 1);
    chk("rst_re", RE, 0);
    chk("rst_busy", TxBusy, 0);
    chk("rst_idle", TxIdle, 1);
    EF = 0; DO = 16'h00FF;
    #1;
    chk("rst_re_ef0", RE, 0);
    chk("rst_idle_ef0", TxIdle, 0);
    repeat (3) cycle();
    Rst = 0;
    repeat (3) cycle();

    // 8N1, 0x00A5, CE every clock
    re_log.delete();
    fifo.push_back(16'h00A5);
    wait_re(r);
    run_until_idle(400);
    chk("t1_re_count", re_log.size(), 1);
    for (int k = 0; k < 10; k++) chk("t1_bit", txd_log[r + 1 + 16 * k + 8], p1[k]);
    chk("t1_busy_last", busy_log[r + 160], 1);
    chk("t1_busy_end", busy_log[r + 161], 0);
    chk("t1_idle", TxIdle, 1);

    // 7 bits, odd parity, two stops, 0x41
    Len = 0; ParEn = 1; ParSel = 2'b00; NumStop = 1;
    re_log.delete();
    fifo.push_back(16'hBE41);
    wait_re(r);
    run_until_idle(400);
    chk("t2_re_count", re_log.size(), 1);
    for (int k = 0; k < 11; k++) chk("t2_bit", txd_log[r + 1 + 16 * k + 8], p2[k]);
    chk("t2_busy_last", busy_log[r + 176], 1);
    chk("t2_busy_end", busy_log[r + 177], 0);

    // back-to-back 8N1 frames
    Len = 1; ParEn = 0; NumStop = 0;
    re_log.delete();
    fifo.push_back(16'h0055);
    fifo.push_back(16'h000F);
    run_until_idle(800);
    chk("t3_re_count", re_log.size(), 2);
    if (re_log.size() == 2) chk("t3_gap", re_log[1] - re_log[0], 16 * 10 + 1);

    // asynchronous reset mid-frame
    re_log.delete();
    fifo.push_back(16'h1234);
    fifo.push_back(16'h00FF);
    wait_re(r);
    while (cyc < r + 50) cycle();
    #2;
    Rst = 1;
    #1;
    chk("t4_txd", TxD, 1);
    chk("t4_re", RE, 0);
    chk("t4_busy", TxBusy, 0);
    m_busy = 0; m_ticks = 0; m_bits.delete(); m_txd = 1;
    repeat (2) cycle();
    fifo.delete();
    repeat (2) cycle();
    Rst = 0;
    re_log.delete();
    repeat (100) cycle();
    chk("t4_no_re", re_log.size(), 0);
    chk("t4_txd_hold", TxD, 1);

    // break during data, released in stop
    re_log.delete();
    fifo.push_back(16'h00FF);
    wait_re(r);
    while (cyc < r + 40) cycle();
    Brk = 1;
    cycle();
    chk("t5_brk_on", TxD, 0);
    while (cyc < r + 150) cycle();
    Brk = 0;
    cycle();
    chk("t5_brk_off", TxD, 1);
    run_until_idle(400);
    chk("t5_busy_last", busy_log[r + 160], 1);
    chk("t5_busy_end", busy_log[r + 161], 0);

    // CE every 4th clock, config churn after load
    ce_div = 4;
    Len = 1; ParEn = 0; NumStop = 0;
    re_log.delete();
    fifo.push_back(16'h003C);
    wait_re(r);
    rand_cfg = 1;
    run_until_idle(2000);
    rand_cfg = 0;
    cnt = 0;
    for (int i = r + 1; i < r + 700; i++) cnt += int'(busy_log[i]);
    chk("t6_frame_len", (cnt >= 637 && cnt <= 640), 1);

    // randomized frames, configs, enable rates and break bursts
    rand_cfg = 1;
    rand_brk = 1;
    for (int f = 0; f < 30; f++) begin
      ce_div = $urandom_range(1, 3);
      fifo.push_back(16'($urandom));
      if ($urandom_range(0, 1) == 1) fifo.push_back(16'($urandom));
      run_until_idle(4000);
    end
    rand_cfg = 0;
    rand_brk = 0;
    Brk = 0;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side serializer for the SSP UART. It sits directly downstream of the transmit FIFO (DPSFnmCE) and pops one word whenever the FIFO is non-empty and the serializer is idle. It shifts that word out on TxD as an asynchronous serial frame: start bit, 7/8 data bits LSB first, optional parity, 1/2 stop bits. Bit timing is derived from an external 16x baud clock-enable.

## Interface
Parameters:
- width, 16: FIFO data width; only DO[7:0] are transmitted, upper bits ignored.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  reset, asynchronous, active-high.
- CE_16x  in  1  single-cycle enable at 16x baud rate.
- EF  in  1  FIFO empty flag.
- DO  in  width  FIFO read data; first-word-fall-through, valid whenever EF=0.
- RE  out  1  FIFO pop strobe, one cycle per word.
- Len  in  1  word length: 0 = 7 bits, 1 = 8 bits.
- NumStop  in  1  0 = 1 stop bit, 1 = 2 stop bits.
- ParEn  in  1  parity bit enable.
- ParSel  in  2  00 odd, 01 even, 10 mark (1), 11 space (0).
- Brk  in  1  force line to break (TxD=0).
- TxD  out  1  serial output, registered.
- TxBusy  out  1  frame in progress.
- TxIdle  out  1  TxBusy=0 and EF=1.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RE = (state==IDLE) & ~EF, combinational.
  - On the same edge: load DO[7:0] into THR; latch Len/NumStop/ParEn/ParSel; clear tick counter and bit counter; go to START.
  - RE is never asserted outside IDLE.
- Tick counter: 4 bits, advances only on CE_16x. A bit ends on the CE_16x where the counter = 15. The counter wraps to 0 and the next bit begins.
- START: TxD=0 for 1 bit, then DATA.
- DATA: TxD=THR[0]; shift THR right at each bit end. Bit counter runs 0..6 (Len=0) or 0..7 (Len=1). After the last bit go to PARITY if ParEn, else STOP.
- PARITY: bit is computed over the transmitted data bits only:
  - odd = ~^data
  - even = ^data
  - mark = 1
  - space = 0
- STOP: TxD=1 for 16 ticks (NumStop=0) or 32 ticks (NumStop=1), then IDLE.
- Config inputs change mid-frame: no effect until the next load.
- Brk: TxD register input forced 0 while Brk=1. The FSM keeps running, so frames are consumed and lost. On Brk deassert, TxD resumes the current state's value on the next edge.
- EF=1 in IDLE: no RE; TxD holds 1 indefinitely.
- TxBusy = (state != IDLE).

## Timing
- Reset values:
  - TxD=1, RE=0, TxBusy=0
  - TxIdle=EF
  - state=IDLE, THR=0, counters=0
- Reset mid-frame: TxD=1 and the FSM is in IDLE immediately (async). The partially sent word is lost.
- Latency: RE edge to TxD falling = 1 clock (registered TxD).
- Frame length: 16·(1+7/8+ParEn+1/2) CE_16x ticks. Example: 8N1 = 160 ticks.
- Back-to-back frames: STOP ends, then one clock in IDLE with RE, then START. The gap is 1 clock, not 1 bit.
- CE_16x held high gives 16 clocks per bit (simulation mode).

## Structure
- Package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - parity select constants PAR_ODD/PAR_EVEN/PAR_MARK/PAR_SPACE
  - BIT_TICKS=16
- Sub-module uart_bit_timer contains the 4-bit tick counter with clear and CE inputs. It outputs a bit_end pulse. It is reused by the future receiver.

## Test plan
- CE_16x=1, 8N1, FIFO holds 0x00A5:
  - Exactly one RE pulse.
  - TxD = 0,1,0,1,0,0,1,0,1,1, each held 16 clocks.
  - Then TxBusy=0 and TxIdle=1.
- Len=0, ParEn=1, ParSel=00, NumStop=1, word 0x41:
  - TxD = 0, 1,0,0,0,0,0,1, parity 1, stop 1,1.
  - Frame = 176 clocks.
- FIFO holds 0x55, 0x0F with 8N1: two RE pulses 161 clocks apart; second START follows 1 clock after the first frame's final stop bit.
- Assert Rst at clock 50 of an 8N1 frame:
  - TxD=1, RE=0, TxBusy=0 immediately.
  - After release with EF=1, TxD stays 1 with no RE.
- Brk=1 during DATA: TxD=0 from the next edge. FSM completes the frame on schedule (TxBusy falls at the normal time). TxD returns to 1 one clock after Brk drops in STOP.
- CE_16x every 4th clock, 8N1: each bit lasts 64 clocks. Config changes mid-frame do not alter the frame.
